// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, D = A - B - Bin, LSB first.
// A single full-subtractor cell feeds a borrow flip-flop; operands shift right
// one bit per clock while difference bits enter the result register at the MSB.
// Optional feature macro: SERIAL_SUB_OVERFLOW_EN adds o_r_ovf (two's-complement
// overflow of the completed operation).
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             i_w_clk,
    input  logic             i_w_rst,
    input  logic             i_w_start,
    input  logic [WIDTH-1:0] i_w_a,
    input  logic [WIDTH-1:0] i_w_b,
    input  logic             i_w_bin,
    output logic             o_r_busy,
    output logic             o_r_done,
    output logic [WIDTH-1:0] o_r_d,
    output logic             o_r_bout
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             o_r_ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    // Full-subtractor cell on the current operand LSBs and the stored borrow.
    logic             a0, b0, diff_bit, borrow_next;
    logic [WIDTH-1:0] r_shifted;

    // Combinational subtractor cell and the result register's shifted image.
    always_comb begin
        a0          = a_q[0];
        b0          = b_q[0];
        diff_bit    = a0 ^ b0 ^ br_q;
        borrow_next = (~a0 & b0) | (~(a0 ^ b0) & br_q);
        r_shifted   = {diff_bit, r_q[WIDTH-1:1]};
    end

    // Next-state and output logic for the IDLE -> SHIFT -> DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        d_d     = d_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_w_start) begin
                    a_d     = i_w_a;
                    b_d     = i_w_b;
                    br_d    = i_w_bin;
                    r_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = r_shifted;
                br_d  = borrow_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Last bit: publish the full result and final borrow together.
                    d_d     = r_shifted;
                    bout_d  = borrow_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    // a0/b0 are the original operand MSBs at this point.
                    ovf_d   = (a0 ^ b0) & (diff_bit ^ a0);
`endif
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset aborts any operation without publishing a result.
    always_ff @(posedge i_w_clk) begin
        if (i_w_rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            d_q     <= d_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign o_r_busy = busy_q;
    assign o_r_done = done_q;
    assign o_r_d    = d_q;
    assign o_r_bout = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign o_r_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed self-checking bench for serial_subtractor (WIDTH = 8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] prev_d = '0;
    logic             prev_bout = 1'b0;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .i_w_clk   (clk),
        .i_w_rst   (rst),
        .i_w_start (start),
        .i_w_a     (a),
        .i_w_b     (b),
        .i_w_bin   (bin),
        .o_r_busy  (busy),
        .o_r_done  (done),
        .o_r_d     (d),
        .o_r_bout  (bout)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .o_r_ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation; optionally pulse a stray start mid-operation at busy cycle glitch_at.
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                          input logic [7:0] exp_d, input logic exp_bout, input logic exp_ovf,
                          input int glitch_at, input string tag);
        int n;
        start = 1'b1; a = ta; b = tb; bin = tbin;
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb; bin = ~tbin;   // operands must already be captured
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            check({tag, "_busy"}, busy, 1);
            check({tag, "_dheld"}, d, prev_d);
            check({tag, "_bheld"}, bout, prev_bout);
            if (n == glitch_at) begin
                start = 1'b1; a = 8'd1; b = 8'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, n, WIDTH);
        check({tag, "_d"}, d, exp_d);
        check({tag, "_bout"}, bout, exp_bout);
        check({tag, "_busy_off"}, busy, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check({tag, "_ovf"}, ovf, exp_ovf);
`else
        if (exp_ovf === 1'bx) check({tag, "_ovf_x"}, 0, 1);
`endif
        prev_d = exp_d;
        prev_bout = exp_bout;
        // Done is a single-cycle strobe and no further operation may start.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check({tag, "_done_off"}, done, 0);
            check({tag, "_idle"}, busy, 0);
            check({tag, "_dkeep"}, d, exp_d);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        @(negedge clk);
        start = 1'b1;   // reset must win over start
        @(negedge clk);
        start = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_d", d, 0);
        check("rst_bout", bout, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", busy, 0);

        run_op(8'd5,   8'd3,   1'b0, 8'h02, 1'b0, 1'b0, -1, "a5b3");
        run_op(8'd3,   8'd5,   1'b0, 8'hFE, 1'b1, 1'b0, -1, "a3b5");
        run_op(8'h80,  8'h01,  1'b0, 8'h7F, 1'b0, 1'b1, -1, "a80b01");
        run_op(8'h00,  8'h00,  1'b1, 8'hFF, 1'b1, 1'b0, -1, "zero_bin");
        run_op(8'hFF,  8'hFF,  1'b0, 8'h00, 1'b0, 1'b0, -1, "ffff");
        run_op(8'hFF,  8'h00,  1'b0, 8'hFF, 1'b0, 1'b0, -1, "ff00");
        run_op(8'd10,  8'd4,   1'b1, 8'h05, 1'b0, 1'b0, -1, "a10b4bin");
        run_op(8'd10,  8'd4,   1'b0, 8'h06, 1'b0, 1'b0,  3, "stray_start");

        // Reset in the middle of an operation: nothing is published.
        start = 1'b1; a = 8'd9; b = 8'd1; bin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (n = 0; n < 3; n++) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_d", d, 0);
        check("abort_bout", bout, 0);
        prev_d = '0;
        prev_bout = 1'b0;
        for (n = 0; n < 10; n++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        run_op(8'd9, 8'd1, 1'b0, 8'h08, 1'b0, 1'b0, -1, "after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor; the inverse-operation counterpart of the combinational full adder used in the basic drills.
- Computes D = A - B - Bin one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- Driven by a start pulse. Reports busy, a one-cycle done strobe, and the final borrow.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- i_w_clk  input  1  clock; all state changes on rising edge.
- i_w_rst  input  1  synchronous, active-high reset.
- i_w_start  input  1  request to start a subtraction; sampled only in IDLE.
- i_w_a  input  WIDTH  minuend; captured on accepted start.
- i_w_b  input  WIDTH  subtrahend; captured on accepted start.
- i_w_bin  input  1  borrow-in; captured on accepted start.
- o_r_busy  output  1  high while an operation is in progress (SHIFT state).
- o_r_done  output  1  one-cycle strobe: result valid.
- o_r_d  output  WIDTH  difference; registered, updated only at completion.
- o_r_bout  output  1  final borrow-out; updated together with o_r_d.

Behaviour:
- Reset (i_w_rst high at an edge) has priority over everything. After reset:
  - state = IDLE
  - o_r_busy = 0, o_r_done = 0, o_r_d = 0, o_r_bout = 0
  - internal shift registers, borrow flip-flop and bit counter = 0
- States: IDLE, SHIFT, DONE.
- IDLE:
  - i_w_start = 1 at edge E0: capture i_w_a, i_w_b, i_w_bin; counter = 0; go to SHIFT; o_r_busy = 1.
  - i_w_start = 0: stay in IDLE.
- SHIFT, one bit per edge:
  - a0, b0 = current LSBs of the operand shift registers; br = borrow flip-flop.
  - diff bit = a0 ^ b0 ^ br.
  - next borrow = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Diff bit shifts into the result shift register from the MSB side; operand registers shift right by one.
  - counter increments.
  - On the edge that processes bit WIDTH-1 (edge E_WIDTH): copy result register to o_r_d and final borrow to o_r_bout; o_r_busy = 0; o_r_done = 1; go to DONE.
- DONE: lasts exactly one cycle; o_r_done = 0 at the next edge; go to IDLE.
- Latency:
  - start sampled at E0; result visible and o_r_done high after E_WIDTH, i.e. WIDTH cycles after acceptance.
  - The next start can be accepted at E_(WIDTH+2) at the earliest. Throughput is one operation per WIDTH+2 cycles.
- i_w_start while in SHIFT or DONE: ignored. No queuing; operands are not recaptured.
- Operand inputs may change freely after the accepting edge without affecting the result.
- o_r_d / o_r_bout hold the previous result for the whole busy period and until the next completion.
- Arithmetic: result equals (A - B - Bin) mod 2^WIDTH. o_r_bout = 1 iff A < B + Bin, unsigned.
- Reset mid-operation (SHIFT or DONE): abort; all outputs and state return to reset values at that edge. A partial result is never published.
- Reset and start at the same edge: reset wins, start is dropped.

Optional Feature:
- Macro: SERIAL_SUB_OVERFLOW_EN.
- Defined:
  - Adds port o_r_ovf (output, 1 bit): two's-complement overflow of the completed operation.
  - o_r_ovf = (A[MSB] ^ B[MSB]) & (D[MSB] ^ A[MSB]).
  - Updated on the same edge as o_r_d; reset to 0; held between operations.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan (WIDTH = 8):
- Reset, then A=5, B=3, Bin=0, start pulse -> after 8 cycles o_r_done=1 for exactly one cycle, o_r_d=0x02, o_r_bout=0; o_r_busy high for 8 cycles.
- A=3, B=5, Bin=0 -> o_r_d=0xFE, o_r_bout=1. With the feature on: A=0x80, B=0x01 -> o_r_d=0x7F, o_r_bout=0, o_r_ovf=1.
- Corners:
  - A=0x00, B=0x00, Bin=1 -> o_r_d=0xFF, o_r_bout=1.
  - A=0xFF, B=0xFF, Bin=0 -> o_r_d=0x00, o_r_bout=0.
  - A=0xFF, B=0x00, Bin=0 -> o_r_d=0xFF, o_r_bout=0.
- Start A=10, B=4; at cycle 3 pulse start with A=1, B=2 and change i_w_a/i_w_b -> result 0x06, o_r_bout=0; second start ignored; only one done strobe.
- Start A=9, B=1; assert i_w_rst at cycle 4 -> busy, done, o_r_d, o_r_bout all 0 next cycle; no done strobe. A fresh start then completes normally.
- Previous result 0x02 held: start a new op -> o_r_d stays 0x02 throughout busy and changes only on the new done cycle.
